// File: rtl/player_missile_logic_if.sv
// Signal bundle between the player missile block and its frame/keyboard/collision
// environment. The master side drives frame timing, fire key, player position and
// collision flags; the slave side (the missile block) returns missile position and status.
interface player_missile_logic_if;
  logic               startOfFrame;
  logic               fireKey;
  logic signed [10:0] playerTopLeftX;
  logic               collisionMonster;
  logic               collisionShield;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               missileActive;
  logic               shotFired;

  modport master (
    output startOfFrame, fireKey, playerTopLeftX, collisionMonster, collisionShield,
    input  topLeftX, topLeftY, missileActive, shotFired
  );

  modport slave (
    input  startOfFrame, fireKey, playerTopLeftX, collisionMonster, collisionShield,
    output topLeftX, topLeftY, missileActive, shotFired
  );
endinterface

// File: rtl/player_missile_logic.sv
// Single player missile: launches from the player's centre, climbs a fixed number
// of 1/64-pixel units per frame, ends on a hit or on leaving the top of the screen,
// then waits a cooldown of whole frames before it can be fired again.
module player_missile_logic #(
  parameter int PLAYER_Y        = 300,
  parameter int PLAYER_WIDTH    = 32,
  parameter int MISSILE_W       = 4,
  parameter int MISSILE_H       = 16,
  parameter int Y_SPEED         = -256,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  player_missile_logic_if.slave bus
);

  localparam int SCALE = 64;
  localparam logic signed [31:0] LAUNCH_Y = 32'((PLAYER_Y - MISSILE_H) * SCALE);

  typedef enum logic [2:0] {
    IDLE_ST,
    READY_ST,
    FLYING_ST,
    START_OF_FRAME_ST,
    POSITION_CHANGE_ST,
    POSITION_LIMITS_ST,
    COOLDOWN_ST
  } state_t;

  state_t state, state_next;

  logic signed [31:0] xpos;
  logic signed [31:0] ypos;
  logic               hit;
  logic [15:0]        cooldown;
  logic               active;
  logic               shot;

  logic launch, clr_pos, clr_hit, clr_cd, latch_hit, load_cd, dec_cd, step_y, deactivate;

  // Fixed-point to pixel conversion, truncating toward zero.
  function automatic logic signed [10:0] to_pixel(input logic signed [31:0] v);
    return 11'(v / 32'sd64);
  endfunction

  // Launch X: missile centred on the player sprite, in fixed point.
  function automatic logic signed [31:0] launch_x(input logic signed [10:0] px);
    logic signed [31:0] cx;
    cx = 32'(px) + 32'(PLAYER_WIDTH / 2) - 32'(MISSILE_W / 2);
    return cx * 32'sd64;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE_ST;
    else         state <= state_next;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    clr_pos    = 1'b0;
    clr_hit    = 1'b0;
    clr_cd     = 1'b0;
    latch_hit  = 1'b0;
    load_cd    = 1'b0;
    dec_cd     = 1'b0;
    step_y     = 1'b0;
    deactivate = 1'b0;
    case (state)
      IDLE_ST: begin
        clr_pos    = 1'b1;
        clr_hit    = 1'b1;
        clr_cd     = 1'b1;
        deactivate = 1'b1;
        if (bus.startOfFrame) state_next = READY_ST;
      end
      READY_ST: begin
        if (bus.fireKey) begin
          launch     = 1'b1;
          state_next = FLYING_ST;
        end
      end
      FLYING_ST: begin
        latch_hit = 1'b1;
        if (bus.startOfFrame) state_next = START_OF_FRAME_ST;
      end
      START_OF_FRAME_ST: begin
        if (hit) begin
          deactivate = 1'b1;
          clr_hit    = 1'b1;
          load_cd    = 1'b1;
          state_next = COOLDOWN_ST;
        end else begin
          state_next = POSITION_CHANGE_ST;
        end
      end
      POSITION_CHANGE_ST: begin
        step_y     = 1'b1;
        state_next = POSITION_LIMITS_ST;
      end
      POSITION_LIMITS_ST: begin
        if (ypos < 0) begin
          deactivate = 1'b1;
          load_cd    = 1'b1;
          state_next = COOLDOWN_ST;
        end else begin
          state_next = FLYING_ST;
        end
      end
      COOLDOWN_ST: begin
        if (bus.startOfFrame) begin
          dec_cd = 1'b1;
          // A counter of 1 reaches 0 on this frame; 0 covers a zero-length cooldown.
          if (cooldown <= 16'd1) state_next = READY_ST;
        end
      end
      default: state_next = IDLE_ST;
    endcase
  end

  // Position, activity, hit latch and cooldown registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      xpos     <= '0;
      ypos     <= '0;
      active   <= 1'b0;
      shot     <= 1'b0;
      hit      <= 1'b0;
      cooldown <= '0;
    end else begin
      shot <= launch;

      if (launch) begin
        xpos <= launch_x(bus.playerTopLeftX);
        ypos <= LAUNCH_Y;
      end else if (clr_pos) begin
        xpos <= '0;
        ypos <= '0;
      end else if (step_y) begin
        ypos <= ypos + 32'(Y_SPEED);
      end

      if (launch)          active <= 1'b1;
      else if (deactivate) active <= 1'b0;

      if (launch || clr_hit) hit <= 1'b0;
      else if (latch_hit)    hit <= hit | bus.collisionMonster | bus.collisionShield;

      if (clr_cd)       cooldown <= '0;
      else if (load_cd) cooldown <= 16'(COOLDOWN_FRAMES);
      else if (dec_cd)  cooldown <= cooldown - 16'd1;
    end
  end

  assign bus.topLeftX      = to_pixel(xpos);
  assign bus.topLeftY      = to_pixel(ypos);
  assign bus.missileActive = active;
  assign bus.shotFired     = shot;

endmodule
